// File: rtl/dma_bus_responder.sv
// Memory-side responder for the OAM DMA engine: arbitrates the main bus between
// the CPU and the DMA master, tracks transfer progress and exports lock/debug flags.
module dma_bus_responder #(
    parameter logic [15:0] OAM_BASE  = 16'hFE00,
    parameter int          OAM_BYTES = 160
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_dma_active,
    input  logic [15:0] i_dma_addr,
    input  logic        i_dma_read_en,
    input  logic        i_dma_write_en,
    input  logic [7:0]  i_dma_wdata,
    output logic [7:0]  o_dma_rdata,
    input  logic [15:0] i_cpu_addr,
    input  logic        i_cpu_read_en,
    input  logic        i_cpu_write_en,
    input  logic [7:0]  i_cpu_wdata,
    output logic [7:0]  o_cpu_rdata,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_read_en,
    output logic        o_mem_write_en,
    output logic [7:0]  o_mem_wdata,
    input  logic [7:0]  i_mem_rdata,
    output logic [15:0] o_high_addr,
    output logic        o_high_read_en,
    output logic        o_high_write_en,
    output logic [7:0]  o_high_wdata,
    input  logic [7:0]  i_high_rdata,
    output logic        o_oam_locked,
    output logic        o_cpu_blocked,
    output logic        o_dma_done,
    output logic        o_dma_err,
    output logic [7:0]  o_byte_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWNED = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic        rd;
        logic        wr;
        logic [7:0]  wdata;
    } bus_req_t;

    localparam logic [16:0] WIN_LO   = {1'b0, OAM_BASE};
    localparam logic [16:0] WIN_HI   = {1'b0, OAM_BASE} + 17'(OAM_BYTES);
    localparam logic [8:0]  DONE_CNT = 9'(OAM_BYTES);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_enter;
    logic        r_oam_locked;
    logic        r_cpu_blocked;
    logic        r_dma_done;
    logic        r_dma_err;
    logic [7:0]  r_byte_count;

    logic        w_own;
    logic        w_in_window;
    logic        w_cpu_high;
    logic        w_cpu_main;
    logic        w_accept;
    logic        w_bad_write;
    logic        w_done_hit;
    logic        w_err_nxt;
    logic [7:0]  w_count_base;
    logic [7:0]  w_count_nxt;
    bus_req_t    w_mem;
    bus_req_t    w_high;

    // Ownership is combinational so strobes in the first dma_active cycle are serviced.
    assign w_own       = i_dma_active | (r_state != S_IDLE);
    assign w_in_window = ({1'b0, i_dma_addr} >= WIN_LO) && ({1'b0, i_dma_addr} < WIN_HI);
    assign w_cpu_high  = (i_cpu_addr[15:8] == 8'hFF);
    assign w_cpu_main  = ~w_cpu_high & (i_cpu_read_en | i_cpu_write_en);
    assign w_accept    = w_own & i_dma_write_en & w_in_window;
    assign w_bad_write = w_own & i_dma_write_en & ~w_in_window;

    always_comb begin
        w_state_nxt = r_state;
        w_enter     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_dma_active) begin
                    w_state_nxt = S_OWNED;
                    w_enter     = 1'b1;
                end
            end
            S_OWNED: begin
                if (!i_dma_active) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                w_state_nxt = i_dma_active ? S_OWNED : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A transfer starting this cycle counts from zero, including a write in that same cycle.
    always_comb begin
        w_count_base = w_enter ? 8'd0 : r_byte_count;
        w_count_nxt  = w_count_base;
        if (w_accept && (w_count_base != 8'hFF)) w_count_nxt = w_count_base + 8'd1;
        w_done_hit = w_accept && ({1'b0, w_count_base} == (DONE_CNT - 9'd1));
        w_err_nxt  = w_bad_write | (r_dma_err & ~w_enter);
    end

    always_comb begin
        w_mem  = '0;
        w_high = '0;
        if (w_cpu_high && (i_cpu_read_en || i_cpu_write_en)) begin
            w_high.addr  = i_cpu_addr;
            w_high.rd    = i_cpu_read_en;
            w_high.wr    = i_cpu_write_en;
            w_high.wdata = i_cpu_write_en ? i_cpu_wdata : 8'h00;
        end
        if (w_own) begin
            if (i_dma_read_en || i_dma_write_en) begin
                w_mem.addr  = i_dma_addr;
                w_mem.rd    = i_dma_read_en;
                w_mem.wr    = i_dma_write_en & w_in_window;
                w_mem.wdata = (i_dma_write_en & w_in_window) ? i_dma_wdata : 8'h00;
            end
        end else if (w_cpu_main) begin
            w_mem.addr  = i_cpu_addr;
            w_mem.rd    = i_cpu_read_en;
            w_mem.wr    = i_cpu_write_en;
            w_mem.wdata = i_cpu_write_en ? i_cpu_wdata : 8'h00;
        end
    end

    always_comb begin
        o_cpu_rdata = 8'hFF;
        if (w_cpu_high && i_cpu_read_en)
            o_cpu_rdata = i_high_rdata;
        else if (!w_cpu_high && i_cpu_read_en && !w_own)
            o_cpu_rdata = i_mem_rdata;
        o_dma_rdata = (w_own && i_dma_read_en) ? i_mem_rdata : 8'hFF;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state       <= S_IDLE;
            r_oam_locked  <= 1'b0;
            r_byte_count  <= 8'd0;
            r_dma_done    <= 1'b0;
            r_cpu_blocked <= 1'b0;
            r_dma_err     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_oam_locked  <= (w_state_nxt != S_IDLE);
            r_byte_count  <= w_count_nxt;
            r_dma_done    <= w_done_hit;
            r_cpu_blocked <= w_own & w_cpu_main;
            r_dma_err     <= w_err_nxt;
        end
    end

    assign o_mem_addr      = w_mem.addr;
    assign o_mem_read_en   = w_mem.rd;
    assign o_mem_write_en  = w_mem.wr;
    assign o_mem_wdata     = w_mem.wdata;
    assign o_high_addr     = w_high.addr;
    assign o_high_read_en  = w_high.rd;
    assign o_high_write_en = w_high.wr;
    assign o_high_wdata    = w_high.wdata;
    assign o_oam_locked    = r_oam_locked;
    assign o_cpu_blocked   = r_cpu_blocked;
    assign o_dma_done      = r_dma_done;
    assign o_dma_err       = r_dma_err;
    assign o_byte_count    = r_byte_count;

endmodule

// File: tb/tb_dma_bus_responder.sv
// Directed bench for dma_bus_responder: routing vector table plus transfer,
// blocking, error, drain re-entry, saturation and reset sequences.
module tb_dma_bus_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        dma_active, dma_read_en, dma_write_en;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata, dma_rdata;
    logic [15:0] cpu_addr;
    logic        cpu_read_en, cpu_write_en;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic [15:0] mem_addr;
    logic        mem_read_en, mem_write_en;
    logic [7:0]  mem_wdata, mem_rdata;
    logic [15:0] high_addr;
    logic        high_read_en, high_write_en;
    logic [7:0]  high_wdata, high_rdata;
    logic        oam_locked, cpu_blocked, dma_done, dma_err;
    logic [7:0]  byte_count;

    int n_tests = 0;
    int n_fail  = 0;
    int dones;

    always #5 clk = ~clk;

    // Simple memory models: read data derived from the address.
    assign mem_rdata  = mem_addr[7:0] ^ mem_addr[15:8];
    assign high_rdata = high_addr[7:0] ^ 8'hA5;

    dma_bus_responder dut (
        .i_clk(clk), .i_reset(reset),
        .i_dma_active(dma_active), .i_dma_addr(dma_addr),
        .i_dma_read_en(dma_read_en), .i_dma_write_en(dma_write_en),
        .i_dma_wdata(dma_wdata), .o_dma_rdata(dma_rdata),
        .i_cpu_addr(cpu_addr), .i_cpu_read_en(cpu_read_en),
        .i_cpu_write_en(cpu_write_en), .i_cpu_wdata(cpu_wdata),
        .o_cpu_rdata(cpu_rdata),
        .o_mem_addr(mem_addr), .o_mem_read_en(mem_read_en),
        .o_mem_write_en(mem_write_en), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata),
        .o_high_addr(high_addr), .o_high_read_en(high_read_en),
        .o_high_write_en(high_write_en), .o_high_wdata(high_wdata),
        .i_high_rdata(high_rdata),
        .o_oam_locked(oam_locked), .o_cpu_blocked(cpu_blocked),
        .o_dma_done(dma_done), .o_dma_err(dma_err), .o_byte_count(byte_count)
    );

    typedef struct {
        logic        act;
        logic [15:0] daddr;
        logic        drd, dwr;
        logic [7:0]  dwd;
        logic [15:0] caddr;
        logic        crd, cwr;
        logic [7:0]  cwd;
        logic [15:0] maddr;
        logic        mrd, mwr;
        logic [7:0]  mwd;
        logic [15:0] haddr;
        logic        hrd, hwr;
        logic [7:0]  hwd, crdata, drdata;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        dma_active = 1'b0; dma_addr = 16'h0; dma_read_en = 1'b0; dma_write_en = 1'b0;
        dma_wdata = 8'h0; cpu_addr = 16'h0; cpu_read_en = 1'b0; cpu_write_en = 1'b0;
        cpu_wdata = 8'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //            act daddr    drd dwr dwd    caddr    crd cwr cwd    maddr    mrd mwr mwd    haddr    hrd hwr hwd    crd    drd
        vecs[0]  = '{0, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 8'hFF, 8'hFF};
        vecs[1]  = '{0, 16'h0000, 0, 0, 8'h00, 16'hC123, 1, 0, 8'h00, 16'hC123, 1, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 8'hE2, 8'hFF};
        vecs[2]  = '{0, 16'h0000, 0, 0, 8'h00, 16'h8000, 0, 1, 8'h3C, 16'h8000, 0, 1, 8'h3C, 16'h0000, 0, 0, 8'h00, 8'hFF, 8'hFF};
        vecs[3]  = '{0, 16'h0000, 0, 0, 8'h00, 16'hFF80, 1, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'hFF80, 1, 0, 8'h00, 8'h25, 8'hFF};
        vecs[4]  = '{0, 16'h0000, 0, 0, 8'h00, 16'hFFFF, 0, 1, 8'h77, 16'h0000, 0, 0, 8'h00, 16'hFFFF, 0, 1, 8'h77, 8'hFF, 8'hFF};
        vecs[5]  = '{0, 16'h0000, 0, 0, 8'h00, 16'hFEFF, 1, 0, 8'h00, 16'hFEFF, 1, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 8'h01, 8'hFF};
        vecs[6]  = '{0, 16'hC010, 1, 1, 8'h99, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 8'hFF, 8'hFF};
        vecs[7]  = '{1, 16'hC010, 1, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'hC010, 1, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 8'hFF, 8'hD0};
        vecs[8]  = '{1, 16'hFE00, 0, 1, 8'hAB, 16'h0000, 0, 0, 8'h00, 16'hFE00, 0, 1, 8'hAB, 16'h0000, 0, 0, 8'h00, 8'hFF, 8'hFF};
        vecs[9]  = '{1, 16'hFE9F, 0, 1, 8'hCD, 16'h0000, 0, 0, 8'h00, 16'hFE9F, 0, 1, 8'hCD, 16'h0000, 0, 0, 8'h00, 8'hFF, 8'hFF};
        vecs[10] = '{1, 16'hFEA0, 0, 1, 8'hEE, 16'h0000, 0, 0, 8'h00, 16'hFEA0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 8'hFF, 8'hFF};
        vecs[11] = '{1, 16'hFDFF, 0, 1, 8'h12, 16'h0000, 0, 0, 8'h00, 16'hFDFF, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 8'hFF, 8'hFF};
        vecs[12] = '{1, 16'hC000, 1, 0, 8'h00, 16'hC123, 1, 0, 8'h00, 16'hC000, 1, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 8'hFF, 8'hC0};
        vecs[13] = '{1, 16'hFE10, 0, 1, 8'h11, 16'hFF80, 0, 1, 8'h5A, 16'hFE10, 0, 1, 8'h11, 16'hFF80, 0, 1, 8'h5A, 8'hFF, 8'hFF};
        vecs[14] = '{1, 16'h0000, 0, 0, 8'h00, 16'hFF90, 1, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'hFF90, 1, 0, 8'h00, 8'h35, 8'hFF};

        clear_in();
        reset = 1'b0;
        tick();
        tick();
        chk("rst_locked", oam_locked, 1'b0);
        chk("rst_count", byte_count, 8'h00);
        chk("rst_done", dma_done, 1'b0);
        chk("rst_err", dma_err, 1'b0);
        chk("rst_blocked", cpu_blocked, 1'b0);
        chk("rst_cpu_rdata", cpu_rdata, 8'hFF);
        chk("rst_dma_rdata", dma_rdata, 8'hFF);
        reset = 1'b1;
        tick();

        // Routing table: inputs are applied and cleared inside one clock phase so state stays IDLE.
        for (int v = 0; v < 15; v++) begin
            dma_active = vecs[v].act; dma_addr = vecs[v].daddr;
            dma_read_en = vecs[v].drd; dma_write_en = vecs[v].dwr; dma_wdata = vecs[v].dwd;
            cpu_addr = vecs[v].caddr; cpu_read_en = vecs[v].crd;
            cpu_write_en = vecs[v].cwr; cpu_wdata = vecs[v].cwd;
            #1;
            chk($sformatf("v%0d_mem_addr", v), mem_addr, vecs[v].maddr);
            chk($sformatf("v%0d_mem_rd", v), mem_read_en, vecs[v].mrd);
            chk($sformatf("v%0d_mem_wr", v), mem_write_en, vecs[v].mwr);
            chk($sformatf("v%0d_mem_wdata", v), mem_wdata, vecs[v].mwd);
            chk($sformatf("v%0d_high_addr", v), high_addr, vecs[v].haddr);
            chk($sformatf("v%0d_high_rd", v), high_read_en, vecs[v].hrd);
            chk($sformatf("v%0d_high_wr", v), high_write_en, vecs[v].hwr);
            chk($sformatf("v%0d_high_wdata", v), high_wdata, vecs[v].hwd);
            chk($sformatf("v%0d_cpu_rdata", v), cpu_rdata, vecs[v].crdata);
            chk($sformatf("v%0d_dma_rdata", v), dma_rdata, vecs[v].drdata);
            clear_in();
            tick();
        end
        chk("table_locked", oam_locked, 1'b0);

        // Full 160-byte transfer C000 -> FE00.
        dones = 0;
        for (int i = 0; i < 160; i++) begin
            dma_active = 1'b1; dma_read_en = 1'b1; dma_write_en = 1'b0;
            dma_addr = 16'hC000 + 16'(i);
            #1;
            chk("xfer_rdata", dma_rdata, 8'(i) ^ 8'hC0);
            tick();
            dones += int'(dma_done);
            if (i == 0) chk("lock_rise", oam_locked, 1'b1);
            dma_read_en = 1'b0; dma_write_en = 1'b1;
            dma_addr = 16'hFE00 + 16'(i); dma_wdata = 8'(i) ^ 8'hC0;
            #1;
            chk("xfer_mem_wr", mem_write_en, 1'b1);
            chk("xfer_mem_addr", mem_addr, 16'hFE00 + 16'(i));
            chk("xfer_mem_wdata", mem_wdata, 8'(i) ^ 8'hC0);
            tick();
            if (i == 159) chk("done_at_160", dma_done, 1'b1);
            dones += int'(dma_done);
        end
        chk("xfer_count", byte_count, 8'd160);
        dma_write_en = 1'b0;
        tick();
        dones += int'(dma_done);
        dma_active = 1'b0;
        tick();
        dones += int'(dma_done);
        chk("drain_locked", oam_locked, 1'b1);
        tick();
        chk("idle_locked", oam_locked, 1'b0);
        chk("xfer_done_once", dones, 1);
        chk("idle_count_kept", byte_count, 8'd160);

        // CPU blocked while DMA owns the bus; high port still usable.
        dma_active = 1'b1;
        tick();
        chk("enter_count_clr", byte_count, 8'd0);
        cpu_addr = 16'hC123; cpu_read_en = 1'b1;
        #1;
        chk("blk_cpu_rdata", cpu_rdata, 8'hFF);
        chk("blk_mem_rd", mem_read_en, 1'b0);
        tick();
        chk("blk_pulse", cpu_blocked, 1'b1);
        cpu_read_en = 1'b0; cpu_write_en = 1'b1; cpu_addr = 16'hFF80; cpu_wdata = 8'h5A;
        #1;
        chk("blk_high_wr", high_write_en, 1'b1);
        chk("blk_high_wdata", high_wdata, 8'h5A);
        chk("blk_mem_wr", mem_write_en, 1'b0);
        tick();
        chk("blk_pulse_end", cpu_blocked, 1'b0);
        cpu_write_en = 1'b0;

        // Out-of-window write, then drain re-entry keeps count and error.
        dma_write_en = 1'b1; dma_addr = 16'hFEA0; dma_wdata = 8'hEE;
        #1;
        chk("err_mem_wr", mem_write_en, 1'b0);
        tick();
        chk("err_set", dma_err, 1'b1);
        chk("err_count", byte_count, 8'd0);
        dma_addr = 16'hFE05;
        tick();
        chk("ok_count", byte_count, 8'd1);
        chk("err_sticky1", dma_err, 1'b1);
        dma_write_en = 1'b0; dma_active = 1'b0;
        tick();
        chk("reent_drain_locked", oam_locked, 1'b1);
        dma_active = 1'b1; cpu_addr = 16'hC123; cpu_read_en = 1'b1;
        #1;
        chk("reent_cpu_rdata", cpu_rdata, 8'hFF);
        tick();
        chk("reent_locked", oam_locked, 1'b1);
        chk("reent_count", byte_count, 8'd1);
        chk("reent_err", dma_err, 1'b1);
        chk("reent_blocked", cpu_blocked, 1'b1);
        cpu_read_en = 1'b0; dma_active = 1'b0;
        tick();
        tick();
        chk("err_sticky_idle", dma_err, 1'b1);
        chk("reent_idle_locked", oam_locked, 1'b0);
        cpu_read_en = 1'b1;
        #1;
        chk("regain_cpu_rdata", cpu_rdata, 8'hE2);
        chk("regain_mem_rd", mem_read_en, 1'b1);
        cpu_read_en = 1'b0;
        tick();
        chk("regain_no_block", cpu_blocked, 1'b0);
        dma_active = 1'b1;
        tick();
        chk("err_clr_enter", dma_err, 1'b0);
        chk("count_clr_enter", byte_count, 8'd0);

        // 300 accepted writes: saturation and single done pulse.
        dones = 0;
        for (int i = 0; i < 300; i++) begin
            dma_write_en = 1'b1; dma_addr = 16'hFE00 + 16'(i % 160); dma_wdata = 8'(i);
            tick();
            dones += int'(dma_done);
            if (i == 159) chk("sat_done_160", dma_done, 1'b1);
            if (i == 254) chk("sat_count_255", byte_count, 8'hFF);
        end
        chk("sat_count", byte_count, 8'hFF);
        chk("sat_done_once", dones, 1);
        dma_write_en = 1'b0; dma_active = 1'b0;
        tick();
        tick();

        // Reset mid-OWNED at byte_count 40 with the error flag set.
        dma_active = 1'b1; dma_write_en = 1'b1; dma_addr = 16'hFE00; dma_wdata = 8'h42;
        #1;
        chk("first_cycle_wr", mem_write_en, 1'b1);
        tick();
        for (int i = 1; i < 40; i++) begin
            dma_addr = 16'hFE00 + 16'(i);
            tick();
        end
        chk("pre_rst_count", byte_count, 8'd40);
        dma_addr = 16'hFEA0;
        tick();
        chk("pre_rst_err", dma_err, 1'b1);
        reset = 1'b0; cpu_addr = 16'hC123; cpu_read_en = 1'b1;
        tick();
        chk("mid_rst_locked", oam_locked, 1'b0);
        chk("mid_rst_count", byte_count, 8'd0);
        chk("mid_rst_err", dma_err, 1'b0);
        chk("mid_rst_done", dma_done, 1'b0);
        chk("mid_rst_blocked", cpu_blocked, 1'b0);
        clear_in();
        reset = 1'b1;
        tick();
        chk("post_rst_locked", oam_locked, 1'b0);
        cpu_addr = 16'hC123; cpu_read_en = 1'b1;
        #1;
        chk("post_rst_cpu_rdata", cpu_rdata, 8'hE2);
        clear_in();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
